// File: rtl/riscv_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package riscv_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam logic ARB_M_LSU = 1'b0;
    localparam logic ARB_M_IF  = 1'b1;

    localparam int ARB_TIMEOUT_W = 16;

endpackage

// File: rtl/riscv_arb_timeout.sv
// Watchdog counter for the memory arbiter. It counts BUSY cycles without a
// response and raises 'expired' once the count reaches TIMEOUT_CYCLES.
module riscv_arb_timeout
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic busy,
    input  logic done,
    output logic expired
);

    localparam logic [ARB_TIMEOUT_W-1:0] LIMIT = ARB_TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [ARB_TIMEOUT_W-1:0] cnt_q;
    logic [ARB_TIMEOUT_W-1:0] cnt_d;

    assign expired = busy && (cnt_q == LIMIT);

    // The count starts at 1 on the grant cycle, so the check fires on the
    // TIMEOUT_CYCLES-th BUSY cycle.
    always_comb begin
        cnt_d = '0;
        if (start) begin
            cnt_d = ARB_TIMEOUT_W'(1);
        end else if (busy && !done && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-master arbiter (LSU = M0, fetch = M1) in front of a single memory port.
// Define RISCV_ARB_RR_EN for round-robin arbitration; otherwise M0 has fixed priority.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        err_o
);

    arb_state_t state_q;
    logic       owner_q;
    logic       prio_q;

    logic anyReq;
    logic winner;
    logic sel;
    logic ownerReq;
    logic idleGrant;
    logic busyActive;
    logic completeOk;
    logic timeoutHit;
    logic readyAny;
    logic expired;

    assign anyReq   = m0_req_i || m1_req_i;
    assign ownerReq = (owner_q == ARB_M_IF) ? m1_req_i : m0_req_i;

    // On contention the favoured master wins; prio_q stays 0 in the fixed build.
    assign winner = (m0_req_i && m1_req_i) ? prio_q
                  : (m1_req_i ? ARB_M_IF : ARB_M_LSU);

    assign sel = (state_q == ARB_IDLE) ? winner : owner_q;

    assign idleGrant  = (state_q == ARB_IDLE) && anyReq;
    assign busyActive = (state_q == ARB_BUSY) && ownerReq;
    assign completeOk = (idleGrant || busyActive) && mem_ready_i;
    assign timeoutHit = busyActive && !mem_ready_i && expired;
    assign readyAny   = completeOk || timeoutHit;

    assign mem_we_o   = (sel == ARB_M_IF) ? m1_we_i   : m0_we_i;
    assign mem_be_o   = (sel == ARB_M_IF) ? m1_be_i   : m0_be_i;
    assign mem_addr_o = (sel == ARB_M_IF) ? m1_addr_i : m0_addr_i;
    assign mem_wd_o   = (sel == ARB_M_IF) ? m1_wd_i   : m0_wd_i;

    assign mem_req_o  = rst_i && (idleGrant || (busyActive && !timeoutHit));
    assign m0_ready_o = rst_i && readyAny && (sel == ARB_M_LSU);
    assign m1_ready_o = rst_i && readyAny && (sel == ARB_M_IF);
    assign err_o      = rst_i && timeoutHit;

    assign m0_rd_o = (timeoutHit && (sel == ARB_M_LSU)) ? 32'h0 : mem_rd_i;
    assign m1_rd_o = (timeoutHit && (sel == ARB_M_IF))  ? 32'h0 : mem_rd_i;

    riscv_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (idleGrant && !mem_ready_i),
        .busy    (state_q == ARB_BUSY),
        .done    (!ownerReq || mem_ready_i),
        .expired (expired)
    );

    // An owner dropping its request mid-transaction returns to IDLE without
    // touching prio_q, since no transfer completed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_M_LSU;
            prio_q  <= ARB_M_LSU;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (anyReq) begin
                        owner_q <= winner;
                        if (!mem_ready_i) begin
                            state_q <= ARB_BUSY;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (!ownerReq || mem_ready_i || expired) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
`ifdef RISCV_ARB_RR_EN
            if (readyAny) begin
                prio_q <= ~sel;
            end
`else
            prio_q <= ARB_M_LSU;
`endif
        end
    end

endmodule
